// File: rtl/mem_arbiter_pkg.sv
// Shared mux/type definitions for the memory arbiter: FSM states, access owner
// and access kind.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} arbState_t;
    typedef enum logic [1:0] {NONE, I, D} arbOwner_t;
    typedef enum logic [1:0] {OP_NONE, OP_READ, OP_WRITE} arbOp_t;

    // A write strobe overrides a simultaneous read strobe.
    function automatic arbOp_t data_op(input logic ren, input logic wen);
        if (wen)
            return OP_WRITE;
        else if (ren)
            return OP_READ;
        else
            return OP_NONE;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of datapath-side and RAM-side request/response signals around the
// arbiter.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          halt;
    logic          iREN;
    logic [AW-1:0] iaddr;
    logic [DW-1:0] iload;
    logic          ihit;
    logic          dREN;
    logic          dWEN;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dstore;
    logic [DW-1:0] dload;
    logic          dhit;
    logic          ramREN;
    logic          ramWEN;
    logic [AW-1:0] ramaddr;
    logic [DW-1:0] ramstore;
    logic [DW-1:0] ramload;
    logic          ram_ready;
    logic          err;

    modport datapath (
        output halt, iREN, iaddr, dREN, dWEN, daddr, dstore,
        input  iload, ihit, dload, dhit, err
    );

    modport ram (
        input  ramREN, ramWEN, ramaddr, ramstore,
        output ramload, ram_ready
    );
endinterface

// File: rtl/arb_watchdog.sv
// Counts BUSY cycles and flags the last one allowed before the arbiter gives
// up on the RAM.
module arb_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    generate
        if (TIMEOUT < 2) begin : g_bad_timeout
            $error("arb_watchdog: TIMEOUT must be at least 2");
        end
    endgenerate

    logic [CW-1:0] cnt;

    // The arbiter leaves BUSY on LAST, so the counter never needs to wrap.
    always_ff @(posedge CLK) begin
        if (RST || clr)
            cnt <= '0;
        else if (en && cnt != LAST)
            cnt <= cnt + 1'b1;
    end

    assign expired = en && (cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data requester has fixed priority over instruction
// fetch, one access at a time, with a watchdog abort for a silent RAM.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          halt,
    input  logic          iREN,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] iload,
    output logic          ihit,
    input  logic          dREN,
    input  logic          dWEN,
    input  logic [AW-1:0] daddr,
    input  logic [DW-1:0] dstore,
    output logic [DW-1:0] dload,
    output logic          dhit,
    output logic          ramREN,
    output logic          ramWEN,
    output logic [AW-1:0] ramaddr,
    output logic [DW-1:0] ramstore,
    input  logic [DW-1:0] ramload,
    input  logic          ram_ready,
    output logic          err
);
    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    assign bus.halt      = halt;
    assign bus.iREN      = iREN;
    assign bus.iaddr     = iaddr;
    assign bus.dREN      = dREN;
    assign bus.dWEN      = dWEN;
    assign bus.daddr     = daddr;
    assign bus.dstore    = dstore;
    assign bus.ramload   = ramload;
    assign bus.ram_ready = ram_ready;

    arbState_t     state;
    arbOwner_t     owner;
    arbOp_t        op;
    logic          halted;
    logic          ram_ren_q;
    logic          ram_wen_q;
    logic [AW-1:0] ram_addr_q;
    logic [DW-1:0] ram_store_q;
    logic [DW-1:0] iload_q;
    logic [DW-1:0] dload_q;
    logic          ihit_q;
    logic          dhit_q;
    logic          err_q;
    logic          expired;
    logic          finish;
    logic          abort;

    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .CLK     (CLK),
        .RST     (RST),
        .clr     (state != BUSY),
        .en      (state == BUSY),
        .expired (expired)
    );

    // A real RAM answer on the last allowed cycle still counts as success.
    assign finish = (state == BUSY) && (bus.ram_ready || expired);
    assign abort  = finish && !bus.ram_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            owner       <= NONE;
            op          <= OP_NONE;
            halted      <= 1'b0;
            ram_ren_q   <= 1'b0;
            ram_wen_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_store_q <= '0;
            iload_q     <= '0;
            dload_q     <= '0;
            ihit_q      <= 1'b0;
            dhit_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ihit_q <= 1'b0;
            dhit_q <= 1'b0;
            err_q  <= 1'b0;
            // Once halted, instruction fetch stays blocked until reset.
            if (bus.halt)
                halted <= 1'b1;

            case (state)
                IDLE: begin
                    if (bus.dREN || bus.dWEN) begin
                        state       <= BUSY;
                        owner       <= D;
                        op          <= data_op(bus.dREN, bus.dWEN);
                        ram_addr_q  <= bus.daddr;
                        ram_store_q <= bus.dstore;
                        ram_wen_q   <= bus.dWEN;
                        ram_ren_q   <= !bus.dWEN;
                    end else if (bus.iREN && !bus.halt && !halted) begin
                        state       <= BUSY;
                        owner       <= I;
                        op          <= OP_READ;
                        ram_addr_q  <= bus.iaddr;
                        ram_store_q <= '0;
                        ram_wen_q   <= 1'b0;
                        ram_ren_q   <= 1'b1;
                    end
                end
                BUSY: begin
                    if (finish) begin
                        state     <= DONE;
                        ram_ren_q <= 1'b0;
                        ram_wen_q <= 1'b0;
                        ihit_q    <= (owner == I);
                        dhit_q    <= (owner == D);
                        err_q     <= abort;
                        if (owner == I)
                            iload_q <= abort ? '0 : bus.ramload;
                        if (owner == D && (op == OP_READ || abort))
                            dload_q <= abort ? '0 : bus.ramload;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    owner <= NONE;
                    op    <= OP_NONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ramREN   = ram_ren_q;
    assign bus.ramWEN   = ram_wen_q;
    assign bus.ramaddr  = ram_addr_q;
    assign bus.ramstore = ram_store_q;
    assign bus.iload    = iload_q;
    assign bus.dload    = dload_q;
    assign bus.ihit     = ihit_q;
    assign bus.dhit     = dhit_q;
    assign bus.err      = err_q;

    assign ramREN   = bus.ramREN;
    assign ramWEN   = bus.ramWEN;
    assign ramaddr  = bus.ramaddr;
    assign ramstore = bus.ramstore;
    assign iload    = bus.iload;
    assign dload    = bus.dload;
    assign ihit     = bus.ihit;
    assign dhit     = bus.dhit;
    assign err      = bus.err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected hits, a
// negedge monitor pops and compares every hit the arbiter emits.
module tb_mem_arbiter;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          halt;
    logic          iREN;
    logic [AW-1:0] iaddr;
    logic [DW-1:0] iload;
    logic          ihit;
    logic          dREN;
    logic          dWEN;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dstore;
    logic [DW-1:0] dload;
    logic          dhit;
    logic          ramREN;
    logic          ramWEN;
    logic [AW-1:0] ramaddr;
    logic [DW-1:0] ramstore;
    logic [DW-1:0] ramload;
    logic          ram_ready;
    logic          err;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .halt      (halt),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .iload     (iload),
        .ihit      (ihit),
        .dREN      (dREN),
        .dWEN      (dWEN),
        .daddr     (daddr),
        .dstore    (dstore),
        .dload     (dload),
        .dhit      (dhit),
        .ramREN    (ramREN),
        .ramWEN    (ramWEN),
        .ramaddr   (ramaddr),
        .ramstore  (ramstore),
        .ramload   (ramload),
        .ram_ready (ram_ready),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        bit          is_d;
        bit          err;
        logic [31:0] load;
        int          at;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        case (a)
            32'h0000_0040: return 32'h2402_0005;
            32'h0000_0044: return 32'h8C43_0004;
            32'h0000_0100: return 32'h0000_1234;
            default:       return 32'hBAD0_0000 | {16'h0, a[15:0]};
        endcase
    endfunction

    assign ramload = ram_word(ramaddr);

    // RAM model: asserts ram_ready after ram_delay BUSY cycles; -1 never answers.
    int ram_delay = 0;
    int bcnt = 0;
    always @(posedge CLK) begin
        #1;
        if (ramREN || ramWEN) begin
            ram_ready = (ram_delay >= 0 && bcnt == ram_delay);
            bcnt++;
        end else begin
            ram_ready = 1'b0;
            bcnt = 0;
        end
    end

    always @(negedge CLK) begin
        if (ihit || dhit) begin
            if (sbq.size() == 0) begin
                chk("unexpected_hit", 32'({dhit, ihit}), 32'h0);
            end else begin
                mon_e = sbq.pop_front();
                chk("hit_owner", 32'({dhit, ihit}), mon_e.is_d ? 32'h2 : 32'h1);
                chk("hit_cycle", 32'(cyc), 32'(mon_e.at));
                chk("hit_err", 32'(err), 32'(mon_e.err));
                chk(mon_e.is_d ? "dload" : "iload", mon_e.is_d ? dload : iload, mon_e.load);
            end
        end else if (err) begin
            chk("err_without_hit", 32'(err), 32'h0);
        end
    end

    initial begin
        RST = 1'b1; halt = 1'b0; iREN = 1'b0; iaddr = '0;
        dREN = 1'b0; dWEN = 1'b0; daddr = '0; dstore = '0; ram_ready = 1'b0;
        tick(2);
        chk("rst_ihit", 32'(ihit), 32'h0);
        chk("rst_dhit", 32'(dhit), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_strobes", 32'({ramREN, ramWEN}), 32'h0);
        chk("rst_ramaddr", ramaddr, 32'h0);
        chk("rst_ramstore", ramstore, 32'h0);
        chk("rst_iload", iload, 32'h0);
        chk("rst_dload", dload, 32'h0);
        RST = 1'b0;
        tick(1);

        // Single fetch
        iaddr = 32'h40; iREN = 1'b1; ram_delay = 0;
        sbq.push_back('{1'b0, 1'b0, 32'h2402_0005, cyc + 2});
        tick(1);
        chk("fetch_ramREN_c1", 32'(ramREN), 32'h1);
        chk("fetch_ramWEN_c1", 32'(ramWEN), 32'h0);
        chk("fetch_ramaddr", ramaddr, 32'h40);
        tick(1);
        chk("fetch_ramREN_c2", 32'(ramREN), 32'h0);
        iREN = 1'b0;
        tick(2);

        // Contention: data first, then fetch
        daddr = 32'h100; dREN = 1'b1; iaddr = 32'h44; iREN = 1'b1;
        sbq.push_back('{1'b1, 1'b0, 32'h0000_1234, cyc + 2});
        sbq.push_back('{1'b0, 1'b0, 32'h8C43_0004, cyc + 5});
        tick(1);
        chk("cont_first_addr", ramaddr, 32'h100);
        chk("cont_first_ren", 32'(ramREN), 32'h1);
        tick(1);
        dREN = 1'b0;
        tick(2);
        chk("cont_second_addr", ramaddr, 32'h44);
        chk("cont_second_ren", 32'(ramREN), 32'h1);
        tick(1);
        iREN = 1'b0;
        tick(2);

        // Write precedence; dload keeps the last read value
        daddr = 32'h200; dstore = 32'hDEAD_BEEF; dREN = 1'b1; dWEN = 1'b1;
        sbq.push_back('{1'b1, 1'b0, 32'h0000_1234, cyc + 2});
        tick(1);
        chk("wr_ramWEN", 32'(ramWEN), 32'h1);
        chk("wr_ramREN", 32'(ramREN), 32'h0);
        chk("wr_ramstore", ramstore, 32'hDEAD_BEEF);
        chk("wr_ramaddr", ramaddr, 32'h200);
        tick(1);
        dREN = 1'b0; dWEN = 1'b0;
        tick(2);

        // Held address with a slow RAM
        daddr = 32'h300; dREN = 1'b1; ram_delay = 4;
        sbq.push_back('{1'b1, 1'b0, 32'hBAD0_0300, cyc + 6});
        tick(1);
        chk("held_addr_c1", ramaddr, 32'h300);
        daddr = 32'h3FC; dstore = 32'h1111_2222;
        for (int i = 2; i <= 5; i++) begin
            tick(1);
            chk("held_addr", ramaddr, 32'h300);
            chk("held_ren", 32'(ramREN), 32'h1);
        end
        tick(1);
        dREN = 1'b0; ram_delay = 0;
        tick(2);

        // Watchdog abort, then a normal fetch proves the FSM is back in IDLE
        iaddr = 32'h80; iREN = 1'b1; ram_delay = -1;
        sbq.push_back('{1'b0, 1'b1, 32'h0, cyc + 17});
        tick(16);
        chk("wd_still_busy", 32'(ramREN), 32'h1);
        tick(1);
        chk("wd_strobe_drop", 32'(ramREN), 32'h0);
        iREN = 1'b0;
        tick(2);
        ram_delay = 0; iaddr = 32'h40; iREN = 1'b1;
        sbq.push_back('{1'b0, 1'b0, 32'h2402_0005, cyc + 2});
        tick(2);
        iREN = 1'b0;
        tick(2);

        // Halt: data still served, fetch never granted, even after halt drops
        halt = 1'b1; iaddr = 32'h40; iREN = 1'b1; daddr = 32'h100; dREN = 1'b1;
        sbq.push_back('{1'b1, 1'b0, 32'h0000_1234, cyc + 2});
        tick(1);
        chk("halt_data_addr", ramaddr, 32'h100);
        tick(1);
        dREN = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("halt_no_fetch", 32'(ramREN), 32'h0);
        end
        halt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("halt_sticky", 32'(ramREN), 32'h0);
        end
        iREN = 1'b0;

        // Reset clears halt; fetch works again
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        iaddr = 32'h40; iREN = 1'b1;
        sbq.push_back('{1'b0, 1'b0, 32'h2402_0005, cyc + 2});
        tick(1);
        chk("post_rst_fetch", 32'(ramREN), 32'h1);
        tick(1);
        iREN = 1'b0;
        tick(2);

        // Reset in BUSY: no hit, no err
        iaddr = 32'h80; iREN = 1'b1; ram_delay = -1;
        tick(3);
        chk("rstbusy_ren_before", 32'(ramREN), 32'h1);
        RST = 1'b1; iREN = 1'b0;
        tick(1);
        chk("rstbusy_strobes", 32'({ramREN, ramWEN}), 32'h0);
        chk("rstbusy_hits", 32'({ihit, dhit}), 32'h0);
        chk("rstbusy_err", 32'(err), 32'h0);
        RST = 1'b0;
        tick(20);
        chk("rstbusy_idle", 32'(ramREN), 32'h0);

        tick(2);
        chk("scoreboard_empty", 32'(sbq.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
